// File: rtl/inst_fetch_pkg.sv
// Shared widths, fetch FSM encoding and reset PC default for the instruction fetch slice.
// Pure definitions; no logic.
package inst_fetch_pkg;

   localparam int ADDR_LEN = 32;
   localparam int INST_LEN = 32;

   localparam logic [ADDR_LEN-1:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_MISS = 1'b1
   } fetch_state_t;

   // Sequential fetch wraps naturally at 2^32.
   function automatic logic [ADDR_LEN-1:0] pc_next(input logic [ADDR_LEN-1:0] pc);
      return pc + ADDR_LEN'(4);
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch <-> memory controller bus: request/address/abort out, ready pulse and word back.
// The fetch unit is the master; the memory controller is the slave.
interface inst_fetch_if;
   import inst_fetch_pkg::*;

   logic                mc_req_o;
   logic [ADDR_LEN-1:0] mc_pc_o;
   logic                mc_jump_o;
   logic                mc_inst_ready_i;
   logic [INST_LEN-1:0] mc_inst_i;

   modport master (
      output mc_req_o,
      output mc_pc_o,
      output mc_jump_o,
      input  mc_inst_ready_i,
      input  mc_inst_i
   );

   modport slave (
      input  mc_req_o,
      input  mc_pc_o,
      input  mc_jump_o,
      output mc_inst_ready_i,
      output mc_inst_i
   );

endinterface

// File: rtl/inst_fetch_icache_dm.sv
// Direct-mapped instruction cache arrays: combinational tag compare/read, synchronous fill.
// Valid bits clear only on reset; there is no other invalidate path.
module icache_dm
   import inst_fetch_pkg::*;
#(
   parameter int IDX_W = 5
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [IDX_W-1:0]                rd_idx,
   input  logic [ADDR_LEN-IDX_W-3:0]       rd_tag,
   output logic                            hit,
   output logic [INST_LEN-1:0]             rd_dat,
   input  logic                            wr_en,
   input  logic [IDX_W-1:0]                wr_idx,
   input  logic [ADDR_LEN-IDX_W-3:0]       wr_tag,
   input  logic [INST_LEN-1:0]             wr_dat
);

   localparam int DEPTH = 1 << IDX_W;
   localparam int TAG_W = ADDR_LEN - IDX_W - 2;

   logic [DEPTH-1:0]    valid;
   logic [TAG_W-1:0]    tag_mem [DEPTH];
   logic [INST_LEN-1:0] dat_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   // Payload arrays need no reset: a line is only read once its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx] <= wr_tag;
         dat_mem[wr_idx] <= wr_dat;
      end
   end

   assign hit    = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
   assign rd_dat = dat_mem[rd_idx];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: one word per cycle from a direct-mapped cache, refills from the memory controller.
// Hit latency 1 cycle, miss latency memory + 1; stall holds outputs, rdy low freezes everything.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int                  ICACHE_IDX_W = 5,
   parameter logic [ADDR_LEN-1:0] RESET_PC     = RESET_PC_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                jump_en_i,
   input  logic [ADDR_LEN-1:0] jump_target_i,
   input  logic                stall_i,
   inst_fetch_if.master        mc,
   output logic                inst_valid_o,
   output logic [INST_LEN-1:0] inst_o,
   output logic [ADDR_LEN-1:0] pc_o
);

   localparam int IDX_HI = ICACHE_IDX_W + 1;
   localparam int TAG_LO = ICACHE_IDX_W + 2;

   fetch_state_t        state, state_nxt;
   logic [ADDR_LEN-1:0] pc, pc_nxt;
   logic                req_q, req_nxt;
   logic [ADDR_LEN-1:0] mcpc_q, mcpc_nxt;
   logic                jump_q, jump_nxt;
   logic                vld_q, vld_nxt;
   logic [INST_LEN-1:0] inst_q, inst_nxt;
   logic [ADDR_LEN-1:0] pco_q, pco_nxt;

   logic                hit;
   logic [INST_LEN-1:0] rd_dat;
   logic                fill;
   logic                cache_we;

   icache_dm #(
      .IDX_W (ICACHE_IDX_W)
   ) u_icache (
      .clk    (clk),
      .rst    (rst),
      .rd_idx (pc[IDX_HI:2]),
      .rd_tag (pc[ADDR_LEN-1:TAG_LO]),
      .hit    (hit),
      .rd_dat (rd_dat),
      .wr_en  (cache_we),
      .wr_idx (mcpc_q[IDX_HI:2]),
      .wr_tag (mcpc_q[ADDR_LEN-1:TAG_LO]),
      .wr_dat (mc.mc_inst_i)
   );

   // The fill must freeze with the rest of the pipe and never land while reset is applied.
   assign cache_we = fill & rdy & rst;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      req_nxt   = req_q;
      mcpc_nxt  = mcpc_q;
      jump_nxt  = 1'b0;
      vld_nxt   = vld_q;
      inst_nxt  = inst_q;
      pco_nxt   = pco_q;
      fill      = 1'b0;

      if (jump_en_i) begin
         pc_nxt    = jump_target_i & ~ADDR_LEN'(3);
         vld_nxt   = 1'b0;
         state_nxt = ST_RUN;
         if (state == ST_MISS) begin
            jump_nxt = 1'b1;
            req_nxt  = 1'b0;
         end
      end else begin
         // A ready pulse seen in RUN is ignored, which covers the stale return right after
         // an abort or reset release without extra tracking.
         unique case (state)
            ST_RUN: begin
               if (!stall_i) begin
                  if (hit) begin
                     vld_nxt  = 1'b1;
                     inst_nxt = rd_dat;
                     pco_nxt  = pc;
                     pc_nxt   = pc_next(pc);
                  end else begin
                     req_nxt   = 1'b1;
                     mcpc_nxt  = pc;
                     vld_nxt   = 1'b0;
                     state_nxt = ST_MISS;
                  end
               end
            end
            ST_MISS: begin
               if (mc.mc_inst_ready_i) begin
                  fill      = 1'b1;
                  req_nxt   = 1'b0;
                  state_nxt = ST_RUN;
                  // Under stall only the line is filled; it is re-read as a hit afterwards.
                  if (!stall_i) begin
                     vld_nxt  = 1'b1;
                     inst_nxt = mc.mc_inst_i;
                     pco_nxt  = pc;
                     pc_nxt   = pc_next(pc);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= ST_RUN;
         pc     <= RESET_PC;
         req_q  <= 1'b0;
         mcpc_q <= '0;
         jump_q <= 1'b0;
         vld_q  <= 1'b0;
         inst_q <= '0;
         pco_q  <= '0;
      end else if (rdy) begin
         state  <= state_nxt;
         pc     <= pc_nxt;
         req_q  <= req_nxt;
         mcpc_q <= mcpc_nxt;
         jump_q <= jump_nxt;
         vld_q  <= vld_nxt;
         inst_q <= inst_nxt;
         pco_q  <= pco_nxt;
      end
   end

   assign mc.mc_req_o  = req_q;
   assign mc.mc_pc_o   = mcpc_q;
   assign mc.mc_jump_o = jump_q;

   assign inst_valid_o = vld_q;
   assign inst_o       = inst_q;
   assign pc_o         = pco_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic against a line-address cache model.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst, rdy, jump_en_i, stall_i;
   logic [31:0] jump_target_i;
   logic        inst_valid_o;
   logic [31:0] inst_o, pc_o;

   int checks = 0;
   int errors = 0;

   int lat     = 5;
   int lat_cnt = -1;
   bit auto_mem = 1'b1;

   // Model: which full word address each cache line holds; data is always mem_word(addr).
   logic [31:0] m_pc, m_mcpc, m_inst, m_pco;
   bit          m_req, m_jump, m_vld;
   logic [31:0] line_addr [32];
   bit          line_ok   [32];

   inst_fetch_if mc ();

   inst_fetch #(
      .ICACHE_IDX_W (5),
      .RESET_PC     (32'h0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .jump_en_i     (jump_en_i),
      .jump_target_i (jump_target_i),
      .stall_i       (stall_i),
      .mc            (mc),
      .inst_valid_o  (inst_valid_o),
      .inst_o        (inst_o),
      .pc_o          (pc_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h0100_0193) ^ 32'h0000_0013;
   endfunction

   function automatic int line_of(input logic [31:0] a);
      return int'((a >> 2) % 32);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic deliver();
      m_vld  = 1'b1;
      m_inst = mem_word(m_pc);
      m_pco  = m_pc;
      m_pc   = m_pc + 32'd4;
   endtask

   task automatic model_step();
      int i;
      if (!rst) begin
         m_pc = 32'h0; m_mcpc = 32'h0; m_inst = 32'h0; m_pco = 32'h0;
         m_req = 1'b0; m_jump = 1'b0; m_vld = 1'b0;
         foreach (line_ok[k]) line_ok[k] = 1'b0;
      end else if (rdy) begin
         m_jump = 1'b0;
         if (jump_en_i) begin
            if (m_req) m_jump = 1'b1;
            m_req = 1'b0;
            m_vld = 1'b0;
            m_pc  = jump_target_i & 32'hFFFF_FFFC;
         end else if (m_req) begin
            if (mc.mc_inst_ready_i) begin
               i = line_of(m_mcpc);
               line_addr[i] = m_mcpc;
               line_ok[i]   = 1'b1;
               m_req        = 1'b0;
               if (!stall_i) deliver();
            end
         end else if (!stall_i) begin
            i = line_of(m_pc);
            if (line_ok[i] && line_addr[i] == m_pc) begin
               deliver();
            end else begin
               m_req  = 1'b1;
               m_mcpc = m_pc;
               m_vld  = 1'b0;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("mc_req",     32'(mc.mc_req_o),  32'(m_req));
      check("mc_pc",      mc.mc_pc_o,        m_mcpc);
      check("mc_jump",    32'(mc.mc_jump_o), 32'(m_jump));
      check("inst_valid", 32'(inst_valid_o), 32'(m_vld));
      check("inst",       inst_o,            m_inst);
      check("pc_o",       pc_o,              m_pco);
   endtask

   // One clock: model consumes current inputs, DUT is sampled 1 time unit after the edge,
   // then the memory responder prepares its inputs for the next cycle.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
      mc.mc_inst_ready_i = 1'b0;
      if (!rst || mc.mc_jump_o || !mc.mc_req_o) begin
         lat_cnt = -1;
      end else if (auto_mem) begin
         if (lat_cnt < 0) lat_cnt = lat - 1;
         else             lat_cnt--;
         if (lat_cnt <= 0) begin
            mc.mc_inst_ready_i = 1'b1;
            mc.mc_inst_i       = mem_word(mc.mc_pc_o);
            lat_cnt            = -1;
         end
      end
   endtask

   task automatic jump_to(input logic [31:0] t);
      jump_en_i     = 1'b1;
      jump_target_i = t;
      tick();
      jump_en_i     = 1'b0;
   endtask

   task automatic wait_valid_pc(input logic [31:0] want, input int budget);
      int n = 0;
      while (!(inst_valid_o === 1'b1 && pc_o === want) && n < budget) begin
         tick();
         n++;
      end
      check("reach_pc", 32'(inst_valid_o === 1'b1 && pc_o === want), 32'd1);
   endtask

   initial begin
      int n;
      int r;
      rst = 1'b0; rdy = 1'b1; jump_en_i = 1'b0; jump_target_i = 32'h0; stall_i = 1'b0;
      mc.mc_inst_ready_i = 1'b0; mc.mc_inst_i = 32'h0;

      // Cold start
      repeat (3) tick();
      check("rst_mc_req", 32'(mc.mc_req_o), 32'd0);
      check("rst_mc_pc", mc.mc_pc_o, 32'h0);
      check("rst_mc_jump", 32'(mc.mc_jump_o), 32'd0);
      check("rst_valid", 32'(inst_valid_o), 32'd0);
      check("rst_inst", inst_o, 32'h0);
      check("rst_pc_o", pc_o, 32'h0);
      rst = 1'b1;
      tick();
      check("cold_req", 32'(mc.mc_req_o), 32'd1);
      check("cold_req_pc", mc.mc_pc_o, 32'h0);
      n = 0;
      while (inst_valid_o !== 1'b1 && n < 30) begin tick(); n++; end
      check("cold_latency", 32'(n), 32'd5);
      check("cold_pc_o", pc_o, 32'h0);
      check("cold_inst", inst_o, 32'h0000_0013);
      check("model_cold_inst", m_inst, 32'h0000_0013);
      tick();
      check("cold_next_req_pc", mc.mc_pc_o, 32'h4);

      // Warm loop over 0x0-0xC
      lat = 2;
      wait_valid_pc(32'hC, 60);
      jump_to(32'h0);
      check("warm_jump_valid", 32'(inst_valid_o), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("warm_valid", 32'(inst_valid_o), 32'd1);
         check("warm_pc_o", pc_o, 32'(i * 4));
         check("warm_no_req", 32'(mc.mc_req_o), 32'd0);
      end

      // Jump during a miss to 0x100
      auto_mem = 1'b0;
      jump_to(32'h100);
      tick();
      check("miss100_req", 32'(mc.mc_req_o), 32'd1);
      check("miss100_pc", mc.mc_pc_o, 32'h100);
      repeat (2) tick();
      check("miss100_hold_pc", mc.mc_pc_o, 32'h100);
      jump_to(32'h40);
      check("abort_pulse", 32'(mc.mc_jump_o), 32'd1);
      check("abort_req", 32'(mc.mc_req_o), 32'd0);
      mc.mc_inst_ready_i = 1'b1;
      mc.mc_inst_i       = mem_word(32'h100);
      tick();
      mc.mc_inst_ready_i = 1'b0;
      check("abort_pulse_end", 32'(mc.mc_jump_o), 32'd0);
      check("late_no_valid", 32'(inst_valid_o), 32'd0);
      check("after_abort_pc", mc.mc_pc_o, 32'h40);
      auto_mem = 1'b1;
      lat = 3;
      wait_valid_pc(32'h40, 30);
      jump_to(32'h100);
      tick();
      check("late_not_cached", 32'(mc.mc_req_o), 32'd1);
      wait_valid_pc(32'h100, 30);

      // Stall across a miss completion at 0x20
      jump_to(32'h20);
      tick();
      check("miss20_pc", mc.mc_pc_o, 32'h20);
      stall_i = 1'b1;
      n = 0;
      while (mc.mc_req_o === 1'b1 && n < 20) begin
         tick();
         n++;
         check("stall_valid_hold", 32'(inst_valid_o), 32'd0);
      end
      check("stall_fill_done", 32'(mc.mc_req_o), 32'd0);
      stall_i = 1'b0;
      tick();
      check("stall_hit_valid", 32'(inst_valid_o), 32'd1);
      check("stall_hit_pc", pc_o, 32'h20);

      // Index conflict between 0x0 and 0x80
      jump_to(32'h0);
      wait_valid_pc(32'h0, 30);
      jump_to(32'h80);
      tick();
      check("conf80_miss", 32'(mc.mc_req_o), 32'd1);
      wait_valid_pc(32'h80, 30);
      jump_to(32'h0);
      tick();
      check("conf0_remiss", 32'(mc.mc_req_o), 32'd1);
      check("conf0_pc", mc.mc_pc_o, 32'h0);
      wait_valid_pc(32'h0, 30);

      // rdy low for 3 cycles in a hit stream
      tick();
      check("rdy_pre_pc", pc_o, 32'h4);
      rdy = 1'b0;
      repeat (3) begin
         tick();
         check("rdy_frozen_pc", pc_o, 32'h4);
         check("rdy_frozen_valid", 32'(inst_valid_o), 32'd1);
      end
      rdy = 1'b1;
      tick();
      check("rdy_resume_8", pc_o, 32'h8);
      tick();
      check("rdy_resume_c", pc_o, 32'hC);

      // PC wrap
      jump_to(32'hFFFF_FFFC);
      wait_valid_pc(32'hFFFF_FFFC, 30);
      tick();
      check("wrap_pc", pc_o, 32'h0);

      // Reset mid-miss with a late ready after release
      jump_to(32'h200);
      auto_mem = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      mc.mc_inst_ready_i = 1'b1;
      mc.mc_inst_i       = mem_word(32'h200);
      tick();
      mc.mc_inst_ready_i = 1'b0;
      check("rst_late_valid", 32'(inst_valid_o), 32'd0);
      check("rst_late_req_pc", mc.mc_pc_o, 32'h0);
      auto_mem = 1'b1;
      wait_valid_pc(32'h0, 40);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 299) != 0);
         rdy       = ($urandom_range(0, 9) != 0);
         stall_i   = ($urandom_range(0, 4) == 0);
         jump_en_i = ($urandom_range(0, 19) == 0);
         r = $urandom_range(0, 3);
         jump_target_i = (r == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                  : 32'($urandom_range(0, 32'h3FF));
         lat = $urandom_range(1, 4);
         if ($urandom_range(0, 29) == 0) begin
            mc.mc_inst_ready_i = 1'b1;
            mc.mc_inst_i       = mem_word(mc.mc_pc_o);
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
